// File: rtl/fetch_stage.sv
// Instruction-fetch stage with IF/ID register. Owns the PC, drives a level-handshake
// request to instruction memory, and applies hazard-unit stall/flush and HLT stop.
module fetch_stage #(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter logic [15:0] NOP_INST = 16'h0000
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_stall,
  input  logic        i_if_flush,
  input  logic [15:0] i_br_target,
  output logic        o_imem_req,
  output logic [15:0] o_imem_addr,
  input  logic        i_imem_valid,
  input  logic [15:0] i_imem_data,
  output logic [15:0] o_if_id_inst,
  output logic [15:0] o_if_id_pc_plus2,
  output logic        o_if_id_valid,
  output logic [15:0] o_pc,
  output logic        o_fetch_halted
);

  typedef enum logic [1:0] {FETCH, DROP, HALT} state_t;

  state_t      r_state, w_state_nxt;
  logic [15:0] r_pc, w_pc_nxt;
  logic [15:0] r_drop_addr, w_drop_addr_nxt;
  logic [15:0] r_inst, w_inst_nxt;
  logic [15:0] r_pc2, w_pc2_nxt;
  logic        r_valid, w_valid_nxt;
  logic        r_halted, w_halted_nxt;
  logic [15:0] w_pc_plus2;
  logic        w_is_hlt;

  assign w_pc_plus2 = r_pc + 16'd2;
  assign w_is_hlt   = (i_imem_data[15:12] == 4'b1111);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state     <= FETCH;
      r_pc        <= RESET_PC;
      r_drop_addr <= RESET_PC;
      r_inst      <= NOP_INST;
      r_pc2       <= 16'h0000;
      r_valid     <= 1'b0;
      r_halted    <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_pc        <= w_pc_nxt;
      r_drop_addr <= w_drop_addr_nxt;
      r_inst      <= w_inst_nxt;
      r_pc2       <= w_pc2_nxt;
      r_valid     <= w_valid_nxt;
      r_halted    <= w_halted_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_pc_nxt        = r_pc;
    w_drop_addr_nxt = r_drop_addr;
    w_inst_nxt      = r_inst;
    w_pc2_nxt       = r_pc2;
    w_valid_nxt     = r_valid;
    w_halted_nxt    = r_halted;
    if (!i_stall) begin
      // Bubble unless a fetched instruction overrides it below.
      w_inst_nxt  = NOP_INST;
      w_pc2_nxt   = 16'h0000;
      w_valid_nxt = 1'b0;
      case (r_state)
        FETCH: begin
          if (i_if_flush) begin
            w_pc_nxt = i_br_target;
            if (!i_imem_valid) begin
              // Request to r_pc is still in flight; remember it so addr stays stable.
              w_state_nxt     = DROP;
              w_drop_addr_nxt = r_pc;
            end
          end else if (i_imem_valid) begin
            w_inst_nxt  = i_imem_data;
            w_pc2_nxt   = w_pc_plus2;
            w_valid_nxt = 1'b1;
            if (w_is_hlt) begin
              w_state_nxt  = HALT;
              w_halted_nxt = 1'b1;
            end else begin
              w_pc_nxt = w_pc_plus2;
            end
          end
        end
        DROP: begin
          if (i_if_flush) w_pc_nxt = i_br_target;
          if (i_imem_valid) w_state_nxt = FETCH;
        end
        HALT: begin
          if (i_if_flush) begin
            w_pc_nxt     = i_br_target;
            w_halted_nxt = 1'b0;
            w_state_nxt  = FETCH;
          end
        end
        default: w_state_nxt = FETCH;
      endcase
    end
  end

  assign o_imem_req       = !i_rst && (r_state != HALT);
  assign o_imem_addr      = (r_state == DROP) ? r_drop_addr : r_pc;
  assign o_if_id_inst     = r_inst;
  assign o_if_id_pc_plus2 = r_pc2;
  assign o_if_id_valid    = r_valid;
  assign o_pc             = r_pc;
  assign o_fetch_halted   = r_halted;

endmodule

// File: tb/tb_fetch_stage.sv
// Randomized scoreboard bench for fetch_stage: a latency-randomized memory, random
// stall/flush, and an abstract fetch model feeding an expected-instruction queue.
module tb_fetch_stage;

  localparam logic [15:0] RST_PC = 16'h0010;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall, flush;
  logic [15:0] tgt;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        mvalid;
  logic [15:0] mdata;
  logic [15:0] if_inst, if_pc2, pc;
  logic        if_valid, halted;

  fetch_stage #(.RESET_PC(RST_PC), .NOP_INST(16'h0000)) dut (
    .i_clk(clk), .i_rst(rst), .i_stall(stall), .i_if_flush(flush),
    .i_br_target(tgt), .o_imem_req(imem_req), .o_imem_addr(imem_addr),
    .i_imem_valid(mvalid), .i_imem_data(mdata), .o_if_id_inst(if_inst),
    .o_if_id_pc_plus2(if_pc2), .o_if_id_valid(if_valid), .o_pc(pc),
    .o_fetch_halted(halted)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [15:0] inst; logic [15:0] pc2; } exp_t;
  exp_t q[$];

  int d_checks = 0, d_errors = 0;
  int m_checks = 0, m_errors = 0;
  logic adv = 1'b0;

  // Abstract fetch model: architectural PC, halted flag, and whether the
  // request in flight belongs to a squashed (wrong) path.
  logic [15:0] m_pc, m_hold;
  logic        m_halted, m_wrong;
  int          lat;
  logic [15:0] cur_data;

  task automatic dchk(input string name, input logic [15:0] act, input logic [15:0] exp);
    d_checks++;
    if (act !== exp) begin
      d_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic new_req();
    lat = $urandom_range(0, 2);
    cur_data = 16'($urandom);
    if ($urandom_range(0, 15) == 0) cur_data[15:12] = 4'hF;
    else if (cur_data[15:12] == 4'hF) cur_data[15] = 1'b0;
  endtask

  task automatic model_reset();
    m_pc = RST_PC; m_hold = RST_PC; m_halted = 1'b0; m_wrong = 1'b0;
    mvalid = 1'b0;
    new_req();
  endtask

  task automatic async_reset();
    adv   = 1'b0;
    stall = 1'b1;
    flush = 1'b0;
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    dchk("rst_pc", pc, RST_PC);
    dchk("rst_req", {15'd0, imem_req}, 16'd0);
    dchk("rst_valid", {15'd0, if_valid}, 16'd0);
    dchk("rst_inst", if_inst, 16'h0000);
    dchk("rst_pc2", if_pc2, 16'h0000);
    dchk("rst_halted", {15'd0, halted}, 16'd0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    bit did_drop_rst = 1'b0;
    rst = 1'b1; stall = 1'b1; flush = 1'b0; tgt = 16'h0; mvalid = 1'b0; mdata = 16'h0;
    #3;
    dchk("init_pc", pc, RST_PC);
    dchk("init_req", {15'd0, imem_req}, 16'd0);
    dchk("init_valid", {15'd0, if_valid}, 16'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_reset();
    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(negedge clk);
      if ((cyc > 1500 && !did_drop_rst && m_wrong) || cyc == 3000) begin
        did_drop_rst = 1'b1;
        async_reset();
        continue;
      end
      dchk("imem_req", {15'd0, imem_req}, {15'd0, !m_halted});
      if (!m_halted) dchk("imem_addr", imem_addr, m_wrong ? m_hold : m_pc);
      dchk("pc", pc, m_pc);
      dchk("halted", {15'd0, halted}, {15'd0, m_halted});
      // memory: respond after lat wait cycles, hold the response while stalled
      if (!m_halted) begin
        if (lat == 0) mvalid = 1'b1;
        else begin mvalid = 1'b0; lat--; end
      end else mvalid = 1'b0;
      mdata = cur_data;
      stall = ($urandom_range(0, 4) == 0);
      flush = ($urandom_range(0, 7) == 0);
      case ($urandom_range(0, 3))
        0: tgt = 16'hFFFE;
        1: tgt = 16'h0040;
        2: tgt = 16'h0030;
        default: tgt = 16'($urandom) & 16'hFFFE;
      endcase
      if (!stall) begin
        if (m_halted) begin
          if (flush) begin m_pc = tgt; m_halted = 1'b0; end
        end else if (m_wrong) begin
          if (flush) m_pc = tgt;
          if (mvalid) m_wrong = 1'b0;
        end else if (flush) begin
          if (!mvalid) begin m_wrong = 1'b1; m_hold = m_pc; end
          m_pc = tgt;
        end else if (mvalid) begin
          q.push_back('{inst: mdata, pc2: m_pc + 16'd2});
          if (mdata[15:12] == 4'hF) m_halted = 1'b1;
          else m_pc = m_pc + 16'd2;
        end
        if (mvalid) new_req();
      end
      adv = !stall;
    end
    @(posedge clk); #2;
    dchk("queue_drained", 16'(q.size()), 16'd0);
    $display("CHECKS %0d ERRORS %0d", d_checks + m_checks, d_errors + m_errors);
    $finish;
  end

  // Monitor: after every advancing edge IF/ID holds either the next expected
  // instruction or a bubble.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk); #1;
      if (adv && !rst) begin
        m_checks++;
        if (if_valid) begin
          if (q.size() == 0) begin
            m_errors++;
            $display("FAIL ifid_unexpected: got inst %h pc2 %h expected bubble", if_inst, if_pc2);
          end else begin
            e = q.pop_front();
            if (if_inst !== e.inst || if_pc2 !== e.pc2) begin
              m_errors++;
              $display("FAIL ifid_inst: got %h/%h expected %h/%h", if_inst, if_pc2, e.inst, e.pc2);
            end
          end
        end else begin
          if (q.size() != 0) begin
            e = q.pop_front();
            m_errors++;
            $display("FAIL ifid_missing: got bubble expected %h/%h", e.inst, e.pc2);
          end else if (if_inst !== 16'h0000 || if_pc2 !== 16'h0000) begin
            m_errors++;
            $display("FAIL ifid_bubble: got %h/%h expected 0000/0000", if_inst, if_pc2);
          end
        end
      end
    end
  end

endmodule
